dds_phase_accumulator: RTL and testbench

DDS_PHASE_ACCUMULATOR -- requirements
Module: dds_phase_accumulator

---
 rtl/dds_pkg.sv | 14 +
 rtl/dds_cfg_shadow.sv | 58 +++++
 rtl/dds_phase_accumulator.sv | 109 ++++++++++
 tb/tb_dds_phase_accumulator.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dds_pkg.sv
// Shared definitions for the DDS phase accumulator: default widths and the
// run-control state encoding exposed on the state output.
package dds_pkg;

  localparam int DEFAULT_PHASE_WIDTH      = 48;
  localparam int DEFAULT_PERIOD_CNT_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_RUN   = 2'd2
  } dds_state_t;

endpackage

// File: rtl/dds_cfg_shadow.sv
// Pending/active shadow registers for phase increment and offset. A load either
// reaches the active set on the next edge or waits for the next wrap in RUN.
module dds_cfg_shadow
  import dds_pkg::*;
#(
  parameter int PHASE_WIDTH = DEFAULT_PHASE_WIDTH
) (
  input  logic                   clk,
  input  logic                   aresetn,
  input  logic [PHASE_WIDTH-1:0] cfg_phase_inc,
  input  logic [PHASE_WIDTH-1:0] cfg_phase_offset,
  input  logic                   cfg_load,
  input  logic                   cfg_apply_at_wrap,
  input  logic                   running,
  input  logic                   wrap_now,
  input  logic                   stop_now,
  output logic [PHASE_WIDTH-1:0] active_inc,
  output logic [PHASE_WIDTH-1:0] active_offset
);

  logic [PHASE_WIDTH-1:0] pending_inc;
  logic [PHASE_WIDTH-1:0] pending_offset;
  logic                   pend_flag;
  logic                   imm_flag;

  // NOTE: sequential state uses non-blocking assignments so every statement
  // below sees the pre-edge values, whatever order they are written in.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      active_inc     <= '0;
      active_offset  <= '0;
      pending_inc    <= '0;
      pending_offset <= '0;
      pend_flag      <= 1'b0;
      imm_flag       <= 1'b0;
    end else begin
      if (imm_flag) begin
        active_inc    <= pending_inc;
        active_offset <= pending_offset;
        imm_flag      <= 1'b0;
      end
      // A deferred config lands on the wrap edge (or a stop) using the
      // previously captured values; a coincident load stays pending.
      if (pend_flag && (wrap_now || stop_now)) begin
        active_inc    <= pending_inc;
        active_offset <= pending_offset;
        pend_flag     <= 1'b0;
      end
      if (cfg_load) begin
        pending_inc    <= cfg_phase_inc;
        pending_offset <= cfg_phase_offset;
        if (cfg_apply_at_wrap && running) pend_flag <= 1'b1;
        else                              imm_flag  <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/dds_phase_accumulator.sv
// DDS phase accumulator with IDLE/ARMED/RUN control, wrap flag, saturating
// completed-period counter and shadowed increment/offset configuration.
module dds_phase_accumulator
  import dds_pkg::*;
#(
  parameter int PHASE_WIDTH      = DEFAULT_PHASE_WIDTH,
  parameter int PERIOD_CNT_WIDTH = DEFAULT_PERIOD_CNT_WIDTH
) (
  input  logic                        clk,
  input  logic                        aresetn,
  input  logic [PHASE_WIDTH-1:0]      cfg_phase_inc,
  input  logic [PHASE_WIDTH-1:0]      cfg_phase_offset,
  input  logic                        cfg_load,
  input  logic                        cfg_apply_at_wrap,
  input  logic                        arm,
  input  logic                        trigger,
  input  logic                        stop,
  output logic [PHASE_WIDTH-1:0]      m_axis_tdata_phase,
  output logic                        m_axis_tvalid_phase,
  output logic                        wrap,
  output logic [PERIOD_CNT_WIDTH-1:0] period_count,
  output logic [1:0]                  state
);

  dds_state_t             state_q;
  dds_state_t             state_d;
  logic [PHASE_WIDTH-1:0] acc;
  logic [PHASE_WIDTH:0]   sum;
  logic [PHASE_WIDTH-1:0] active_inc;
  logic [PHASE_WIDTH-1:0] active_offset;
  logic                   running;
  logic                   start;
  logic                   step;
  logic                   wrap_now;
  logic                   stop_now;

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // NOTE: the default assignment first keeps this combinational block from
  // inferring a latch on paths that do not change state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (arm) state_d = ST_ARMED;
      ST_ARMED: begin
        if (stop)         state_d = ST_IDLE;
        else if (trigger) state_d = ST_RUN;
      end
      ST_RUN:   if (stop) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  assign running  = (state_q == ST_RUN);
  assign start    = (state_q == ST_ARMED) && (state_d == ST_RUN);
  assign step     = running && (state_d == ST_RUN);
  assign stop_now = stop && (state_q != ST_IDLE);
  assign sum      = {1'b0, acc} + {1'b0, active_inc};
  assign wrap_now = step && sum[PHASE_WIDTH];
  assign state    = state_q;

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      acc                 <= '0;
      m_axis_tdata_phase  <= '0;
      m_axis_tvalid_phase <= 1'b0;
      wrap                <= 1'b0;
      period_count        <= '0;
    end else if (start) begin
      acc                 <= '0;
      m_axis_tdata_phase  <= active_offset;
      m_axis_tvalid_phase <= 1'b1;
      wrap                <= 1'b0;
      period_count        <= '0;
    end else if (step) begin
      acc                <= sum[PHASE_WIDTH-1:0];
      m_axis_tdata_phase <= sum[PHASE_WIDTH-1:0] + active_offset;
      wrap               <= sum[PHASE_WIDTH];
      if (sum[PHASE_WIDTH] && (period_count != '1))
        period_count <= period_count + PERIOD_CNT_WIDTH'(1);
    end else begin
      // Idle and armed: output quiet, period_count keeps the last run's count.
      acc                 <= '0;
      m_axis_tdata_phase  <= '0;
      m_axis_tvalid_phase <= 1'b0;
      wrap                <= 1'b0;
    end
  end

  dds_cfg_shadow #(
    .PHASE_WIDTH(PHASE_WIDTH)
  ) u_cfg_shadow (
    .clk              (clk),
    .aresetn          (aresetn),
    .cfg_phase_inc    (cfg_phase_inc),
    .cfg_phase_offset (cfg_phase_offset),
    .cfg_load         (cfg_load),
    .cfg_apply_at_wrap(cfg_apply_at_wrap),
    .running          (running),
    .wrap_now         (wrap_now),
    .stop_now         (stop_now),
    .active_inc       (active_inc),
    .active_offset    (active_offset)
  );

endmodule

// File: tb/tb_dds_phase_accumulator.sv
// Bench for dds_phase_accumulator: directed scenarios plus random control and
// config traffic, compared every cycle against an arithmetic reference model.
module tb_dds_phase_accumulator;

  localparam int PW = 48;
  localparam int CW = 4;
  localparam longint unsigned MOD    = 64'd1 << PW;
  localparam longint unsigned MASK   = MOD - 64'd1;
  localparam longint unsigned PC_MAX = (64'd1 << CW) - 64'd1;
  localparam longint unsigned P43 = 64'd1 << 43;
  localparam longint unsigned P44 = 64'd1 << 44;
  localparam longint unsigned P45 = 64'd1 << 45;
  localparam longint unsigned P46 = 64'd1 << 46;
  localparam longint unsigned P47 = 64'd1 << 47;

  logic          clk = 1'b0;
  logic          aresetn;
  logic [PW-1:0] cfg_phase_inc;
  logic [PW-1:0] cfg_phase_offset;
  logic          cfg_load;
  logic          cfg_apply_at_wrap;
  logic          arm;
  logic          trigger;
  logic          stop;
  logic [PW-1:0] m_axis_tdata_phase;
  logic          m_axis_tvalid_phase;
  logic          wrap;
  logic [CW-1:0] period_count;
  logic [1:0]    state;

  int checks = 0;
  int errors = 0;

  // Reference model: phase is n*inc+offset modulo 2^PW, built up sample by sample.
  int              m_state;
  int              m_n;
  longint unsigned m_acc, m_data, m_pc;
  bit              m_valid, m_wrap;
  longint unsigned act_inc, act_off, pen_inc, pen_off;
  bit              pend, imm;

  always #5 clk = ~clk;

  dds_phase_accumulator #(
    .PHASE_WIDTH     (PW),
    .PERIOD_CNT_WIDTH(CW)
  ) dut (
    .clk                (clk),
    .aresetn            (aresetn),
    .cfg_phase_inc      (cfg_phase_inc),
    .cfg_phase_offset   (cfg_phase_offset),
    .cfg_load           (cfg_load),
    .cfg_apply_at_wrap  (cfg_apply_at_wrap),
    .arm                (arm),
    .trigger            (trigger),
    .stop               (stop),
    .m_axis_tdata_phase (m_axis_tdata_phase),
    .m_axis_tvalid_phase(m_axis_tvalid_phase),
    .wrap               (wrap),
    .period_count       (period_count),
    .state              (state)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_n = 0;
    m_acc = 0; m_data = 0; m_pc = 0; m_valid = 0; m_wrap = 0;
    act_inc = 0; act_off = 0; pen_inc = 0; pen_off = 0; pend = 0; imm = 0;
  endtask

  task automatic model_update();
    int nxt;
    bit stop_now, wrap_now;
    longint unsigned sum;
    if (!aresetn) begin
      model_reset();
      return;
    end
    wrap_now = 1'b0;
    stop_now = stop && (m_state != 0);
    case (m_state)
      0:       nxt = arm ? 1 : 0;
      1:       nxt = stop ? 0 : (trigger ? 2 : 1);
      default: nxt = stop ? 0 : 2;
    endcase
    if (m_state == 1 && nxt == 2) begin
      m_acc = 0; m_data = act_off; m_valid = 1; m_wrap = 0; m_pc = 0; m_n = 0;
    end else if (m_state == 2 && nxt == 2) begin
      sum      = m_acc + act_inc;
      wrap_now = (sum >= MOD);
      m_acc    = wrap_now ? sum - MOD : sum;
      m_data   = (m_acc + act_off) % MOD;
      m_wrap   = wrap_now;
      if (wrap_now && m_pc < PC_MAX) m_pc++;
      m_n++;
    end else begin
      m_acc = 0; m_data = 0; m_valid = 0; m_wrap = 0;
    end
    if (imm) begin
      act_inc = pen_inc; act_off = pen_off; imm = 0;
    end
    if (pend && (wrap_now || stop_now)) begin
      act_inc = pen_inc; act_off = pen_off; pend = 0;
    end
    if (cfg_load) begin
      pen_inc = 64'(cfg_phase_inc);
      pen_off = 64'(cfg_phase_offset);
      if (cfg_apply_at_wrap && m_state == 2) pend = 1;
      else                                   imm  = 1;
    end
    m_state = nxt;
  endtask

  task automatic compare_all();
    check("tvalid", 64'(m_axis_tvalid_phase), 64'(m_valid));
    check("tdata", 64'(m_axis_tdata_phase), m_data);
    check("wrap", 64'(wrap), 64'(m_wrap));
    check("period_count", 64'(period_count), m_pc);
    check("state", 64'(state), 64'(m_state));
  endtask

  // One clock: model follows the edge, outputs are sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
    compare_all();
  endtask

  task automatic load_cfg(input longint unsigned inc, input longint unsigned off, input bit at_wrap);
    cfg_phase_inc     = PW'(inc);
    cfg_phase_offset  = PW'(off);
    cfg_apply_at_wrap = at_wrap;
    cfg_load          = 1'b1;
    tick();
    cfg_load          = 1'b0;
    cfg_apply_at_wrap = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1; tick(); stop = 1'b0;
  endtask

  task automatic start_run();
    arm = 1'b1; tick(); arm = 1'b0;
    trigger = 1'b1; tick(); trigger = 1'b0;
  endtask

  task automatic run_until(input int target);
    int budget = 200;
    while (m_n < target && budget > 0) begin
      tick();
      budget--;
    end
    check("run_until_budget", 64'(m_n), 64'(target));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    longint unsigned prev;
    aresetn = 1'b0; cfg_phase_inc = '0; cfg_phase_offset = '0; cfg_load = 1'b0;
    cfg_apply_at_wrap = 1'b0; arm = 1'b0; trigger = 1'b0; stop = 1'b0;
    model_reset();
    repeat (3) tick();
    check("rst_tvalid", 64'(m_axis_tvalid_phase), 64'd0);
    check("rst_state", 64'(state), 64'd0);
    aresetn = 1'b1;
    tick();

    // Plain ramp: inc 2^44, wraps every 16 samples.
    load_cfg(P44, 0, 1'b0); tick();
    start_run();
    check("A_s0_data", 64'(m_axis_tdata_phase), 64'd0);
    check("A_s0_valid", 64'(m_axis_tvalid_phase), 64'd1);
    tick();
    check("A_s1_data", 64'(m_axis_tdata_phase), P44);
    run_until(15); check("A_s15_wrap", 64'(wrap), 64'd0);
    run_until(16); check("A_s16_wrap", 64'(wrap), 64'd1);
    check("A_s16_pc", 64'(period_count), 64'd1);
    run_until(17); check("A_s17_wrap", 64'(wrap), 64'd0);
    run_until(32); check("A_s32_wrap", 64'(wrap), 64'd1);
    check("A_s32_pc", 64'(period_count), 64'd2);
    pulse_stop();
    check("A_stop_valid", 64'(m_axis_tvalid_phase), 64'd0);
    check("A_stop_pc_kept", 64'(period_count), 64'd2);

    // Offset 2^47, inc 2^46.
    load_cfg(P46, P47, 1'b0); tick();
    start_run();
    check("B_s0_data", 64'(m_axis_tdata_phase), P47);
    run_until(2); check("B_s2_data", 64'(m_axis_tdata_phase), 64'd0);
    run_until(3); check("B_s3_wrap", 64'(wrap), 64'd0);
    run_until(4); check("B_s4_wrap", 64'(wrap), 64'd1);
    pulse_stop();

    // Deferred increment change, load coinciding with a wrap, stop with pending.
    load_cfg(P44, 0, 1'b0); tick();
    start_run();
    run_until(5);
    load_cfg(P45, 0, 1'b1);
    run_until(15); prev = 64'(m_axis_tdata_phase);
    run_until(16);
    check("C_s16_step", (64'(m_axis_tdata_phase) - prev) & MASK, P44);
    check("C_s16_wrap", 64'(wrap), 64'd1);
    run_until(17); check("C_s17_data", 64'(m_axis_tdata_phase), P45);
    run_until(23);
    load_cfg(P46, 0, 1'b1);
    check("C_s24_wrap", 64'(wrap), 64'd1);
    prev = 64'(m_axis_tdata_phase);
    run_until(25);
    check("C_s25_step", (64'(m_axis_tdata_phase) - prev) & MASK, P45);
    run_until(32); check("C_s32_wrap", 64'(wrap), 64'd1);
    run_until(33); check("C_s33_data", 64'(m_axis_tdata_phase), P46);
    load_cfg(P43, 0, 1'b1);
    pulse_stop();
    start_run();
    run_until(1); check("C_stop_applied", 64'(m_axis_tdata_phase), P43);
    pulse_stop();

    // Strobe priorities.
    arm = 1'b1; trigger = 1'b1; tick(); arm = 1'b0; trigger = 1'b0;
    check("D_arm_trig_state", 64'(state), 64'd1);
    check("D_arm_trig_valid", 64'(m_axis_tvalid_phase), 64'd0);
    stop = 1'b1; trigger = 1'b1; tick(); stop = 1'b0; trigger = 1'b0;
    check("D_stop_trig_state", 64'(state), 64'd0);

    // Period counter saturation.
    load_cfg(P47, 0, 1'b0); tick();
    start_run();
    run_until(40);
    check("E_pc_sat", 64'(period_count), PC_MAX);
    pulse_stop();
    check("E_pc_sat_idle", 64'(period_count), PC_MAX);

    // Random control and config traffic.
    for (int i = 0; i < 1500; i++) begin
      arm     = ($urandom_range(0, 7) == 0);
      trigger = ($urandom_range(0, 5) == 0);
      stop    = ($urandom_range(0, 24) == 0);
      cfg_load = ($urandom_range(0, 11) == 0);
      cfg_apply_at_wrap = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0)
        cfg_phase_inc = PW'({$urandom, $urandom});
      else
        cfg_phase_inc = PW'(64'd1 << $urandom_range(40, 47));
      cfg_phase_offset = PW'({$urandom, $urandom});
      tick();
    end
    arm = 1'b0; trigger = 1'b0; cfg_load = 1'b0; cfg_apply_at_wrap = 1'b0;
    pulse_stop();

    // Asynchronous reset in the middle of a run.
    load_cfg(P44, 0, 1'b0); tick();
    start_run();
    run_until(7);
    #2 aresetn = 1'b0;
    model_reset();
    #1;
    check("F_rst_valid", 64'(m_axis_tvalid_phase), 64'd0);
    check("F_rst_data", 64'(m_axis_tdata_phase), 64'd0);
    check("F_rst_wrap", 64'(wrap), 64'd0);
    check("F_rst_pc", 64'(period_count), 64'd0);
    check("F_rst_state", 64'(state), 64'd0);
    tick();
    aresetn = 1'b1;
    tick();
    start_run();
    check("F_s0_data", 64'(m_axis_tdata_phase), 64'd0);
    check("F_s0_valid", 64'(m_axis_tvalid_phase), 64'd1);
    pulse_stop();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
